bus_arbiter_2to1: RTL and testbench
===================================

Name: bus_arbiter_2to1

Overview:
- Two-master, one-slave arbiter on the 32-bit address/data waitrequest bus.
- Sits directly upstream of the address-decoding interconnect and drives its single slave port; it merges the CPU data port and the debug/host bridge onto that port.
- Round-robin grant, locked for the whole transfer.
- Zero added latency when the downstream slave does not stall.

Parameters:
- TIMEOUT_CYCLES, 256, maximum cycles a granted transfer may stall before forced termination. Used only with BUS_ARB_TIMEOUT_EN. Legal range 2..65535.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- s0_bus_addr / s1_bus_addr  in  32  master 0/1 address
- s0_bus_read / s1_bus_read  in  1  master 0/1 read request
- s0_bus_write / s1_bus_write  in  1  master 0/1 write request
- s0_bus_writedata / s1_bus_writedata  in  32  master 0/1 write data
- s0_bus_byteenable / s1_bus_byteenable  in  4  master 0/1 byte enables
- s0_bus_readdata / s1_bus_readdata  out  32  read data to master 0/1
- s0_bus_response / s1_bus_response  out  2  response to master 0/1
- s0_bus_waitrequest / s1_bus_waitrequest  out  1  stall to master 0/1
- m0_bus_addr  out  32  downstream address
- m0_bus_read / m0_bus_write  out  1  downstream read/write strobes
- m0_bus_writedata  out  32  downstream write data
- m0_bus_byteenable  out  4  downstream byte enables
- m0_bus_readdata  in  32  downstream read data
- m0_bus_response  in  2  downstream response
- m0_bus_waitrequest  in  1  downstream stall
- timeout_pulse  out  1  one-cycle flag on forced termination; tied 0 without the macro

Interface timing is fixed as follows: one clock (clk); reset rst_n is asynchronous, active-low.

Behaviour:
- A master is requesting when its read or write is high. Masters assert read and write together only in error; in that case read wins.
- Response codes: 00 OKAY, 10 SLVERR.
- Registered state:
  - state: IDLE or BUSY.
  - grant_q: 0 or 1.
  - last_q: last master served.
  - timeout counter.
- Reset (async assert):
  - state=IDLE, grant_q=0, last_q=1 (master 0 wins the first tie), counter=0, timeout_pulse=0.
  - While rst_n is low: m0_bus_read=m0_bus_write=0, and both s*_bus_waitrequest=1.
- IDLE arbitration (combinational):
  - Only one requester: it wins.
  - Both requesting: the master other than last_q wins.
  - The winner's addr, writedata, byteenable, read and write go to m0 in the same cycle.
- IDLE completion:
  - m0_bus_waitrequest=0: the transfer completes this cycle. The winner sees waitrequest=0 and gets readdata/response. last_q is set to the winner. Stay in IDLE.
  - m0_bus_waitrequest=1: go to BUSY, with grant_q set to the winner.
- BUSY:
  - The grant_q master is forwarded regardless of the other master's requests.
  - On m0_bus_waitrequest=0: complete, last_q=grant_q, go to IDLE.
  - If the granted master drops both read and write while BUSY (a protocol violation), go to IDLE without updating last_q. No completion is signalled.
- Non-granted master: waitrequest=1, readdata=0, response=00.
- No requester in IDLE:
  - m0 strobes are 0.
  - m0 address/data/byteenable carry master 0's values (don't care downstream).
  - Both waitrequests are 0.
- Back-to-back transfers are allowed. A completing master that still requests next cycle is re-arbitrated normally, so alternation occurs under contention.
- Readdata and response are valid only in the completion cycle. The arbiter does not register them.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- With the macro defined:
  - The counter clears on entry to BUSY and increments each BUSY cycle with m0_bus_waitrequest=1.
  - When the count reaches TIMEOUT_CYCLES-1 with the stall still present, that cycle is a forced completion:
    - granted master sees waitrequest=0, readdata=0, response=10;
    - m0_bus_read and m0_bus_write are driven 0;
    - timeout_pulse=1 for that cycle;
    - last_q is updated and the state returns to IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Without the macro: there is no counter, BUSY waits indefinitely, and timeout_pulse=0.

Decomposition:
- Shared package bus_pkg holds:
  - BUS_ADDR_W=32, BUS_DATA_W=32, BUS_BE_W=4;
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - arb_state_t enum {ARB_IDLE, ARB_BUSY}.
- One natural sub-module, rr_grant_2: the two-input round-robin pick from the request pair and last_q. It is purely combinational.
- The state, lock and timeout logic stay in the top.

Test Plan:
1. Reset, then master 0 reads 0x0000_0104 with waitrequest held low and readdata=0x1234_5678 → same-cycle completion: s0 gets 0x1234_5678 with response 00; m0_bus_read is high for exactly 1 cycle.
2. Both masters write in the same cycle (s0 to 0x100 data 0xA, s1 to 0x200 data 0xB), slave stalls 3 cycles each → s0's write is issued first (last_q=1 after reset), then s1's. While the other master is served, the waiting master's waitrequest stays 1 and m0_bus_addr never changes mid-stall.
3. Both masters request continuously for 6 single-cycle transfers → grants alternate 0,1,0,1,0,1.
4. s1 read stalled 5 cycles while s0 toggles requests → m0 stays locked on s1's address; s0 waitrequest=1 throughout; s1 completes on cycle 6.
5. rst_n pulsed low during a BUSY stall → m0 strobes drop asynchronously. After release the state is IDLE, and a simultaneous request pair grants master 0.
6. With BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave holds waitrequest=1 forever → the 8th BUSY cycle gives response 10, readdata 0, timeout_pulse=1, and m0 strobes 0. The next queued master is granted the following cycle.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus widths, response codes and arbiter state encoding for the
// 32-bit address/data waitrequest bus.
package bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // A master requests when either strobe is high.
  function automatic logic bus_req(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/bus_arbiter_2to1_rr_grant.sv
// Two-input round-robin pick: a lone requester wins, a tie goes to the master
// that was not served last.
module rr_grant_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       any_req
);

  // Winner selection from the request pair.
  always_comb begin
    grant   = 1'b0;
    any_req = |req;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Two-master to one-slave round-robin arbiter, grant locked for the transfer.
// Optional stall watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter_2to1
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BUS_ADDR_W-1:0] s0_bus_addr,
  input  logic                  s0_bus_read,
  input  logic                  s0_bus_write,
  input  logic [BUS_DATA_W-1:0] s0_bus_writedata,
  input  logic [BUS_BE_W-1:0]   s0_bus_byteenable,
  output logic [BUS_DATA_W-1:0] s0_bus_readdata,
  output logic [1:0]            s0_bus_response,
  output logic                  s0_bus_waitrequest,
  input  logic [BUS_ADDR_W-1:0] s1_bus_addr,
  input  logic                  s1_bus_read,
  input  logic                  s1_bus_write,
  input  logic [BUS_DATA_W-1:0] s1_bus_writedata,
  input  logic [BUS_BE_W-1:0]   s1_bus_byteenable,
  output logic [BUS_DATA_W-1:0] s1_bus_readdata,
  output logic [1:0]            s1_bus_response,
  output logic                  s1_bus_waitrequest,
  output logic [BUS_ADDR_W-1:0] m0_bus_addr,
  output logic                  m0_bus_read,
  output logic                  m0_bus_write,
  output logic [BUS_DATA_W-1:0] m0_bus_writedata,
  output logic [BUS_BE_W-1:0]   m0_bus_byteenable,
  input  logic [BUS_DATA_W-1:0] m0_bus_readdata,
  input  logic [1:0]            m0_bus_response,
  input  logic                  m0_bus_waitrequest,
  output logic                  timeout_pulse
);

  arb_state_t            state_r, state_nxt_s;
  logic                  grant_r, grant_nxt_s;
  logic                  last_r, last_nxt_s;
  logic [1:0]            req_s;
  logic                  win_s, any_req_s;
  logic                  sel_s, active_s, done_s, tmo_hit_s;
  logic                  rd_sel_s, wr_sel_s;
  logic [BUS_DATA_W-1:0] rdata_s;
  logic [1:0]            resp_s;

  assign req_s = {bus_req(s1_bus_read, s1_bus_write), bus_req(s0_bus_read, s0_bus_write)};

  rr_grant_2 u_rr (
    .req     (req_s),
    .last    (last_r),
    .grant   (win_s),
    .any_req (any_req_s)
  );

  // While locked the granted master is forwarded; otherwise the fresh winner.
  assign sel_s    = (state_r == ARB_BUSY) ? grant_r : win_s;
  assign active_s = req_s[sel_s];
  assign rd_sel_s = sel_s ? s1_bus_read  : s0_bus_read;
  assign wr_sel_s = sel_s ? s1_bus_write : s0_bus_write;
  assign done_s   = active_s & (~m0_bus_waitrequest | tmo_hit_s);
  assign rdata_s  = (done_s && !tmo_hit_s) ? m0_bus_readdata : {BUS_DATA_W{1'b0}};
  assign resp_s   = tmo_hit_s ? RESP_SLVERR : (done_s ? m0_bus_response : RESP_OKAY);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;

  // Forced completion once the lock has stalled TIMEOUT_CYCLES cycles.
  assign tmo_hit_s = (state_r == ARB_BUSY) && req_s[grant_r] && m0_bus_waitrequest &&
                     (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Stall counter next value: cleared in IDLE so it starts at zero in BUSY.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (state_r == ARB_IDLE) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (m0_bus_waitrequest) begin
      cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end
`else
  logic unused_tmo_s;
  assign unused_tmo_s = ^TIMEOUT_CYCLES;
  assign tmo_hit_s    = 1'b0;
`endif

  assign timeout_pulse = rst_n & tmo_hit_s;

  // State, lock and round-robin history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB_IDLE;
      grant_r <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  // Next-state logic: lock on a stall, release on completion or abandonment.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    last_nxt_s  = last_r;
    case (state_r)
      ARB_IDLE: begin
        if (any_req_s && m0_bus_waitrequest) begin
          state_nxt_s = ARB_BUSY;
          grant_nxt_s = win_s;
        end else if (any_req_s) begin
          last_nxt_s = win_s;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (!req_s[grant_r]) begin
          // Granted master walked away: drop the lock, history untouched.
          state_nxt_s = ARB_IDLE;
        end else if (!m0_bus_waitrequest || tmo_hit_s) begin
          state_nxt_s = ARB_IDLE;
          last_nxt_s  = grant_r;
        end else begin
          state_nxt_s = ARB_BUSY;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // Output mux: forward the selected master, stall everyone else.
  always_comb begin
    m0_bus_addr        = sel_s ? s1_bus_addr       : s0_bus_addr;
    m0_bus_writedata   = sel_s ? s1_bus_writedata  : s0_bus_writedata;
    m0_bus_byteenable  = sel_s ? s1_bus_byteenable : s0_bus_byteenable;
    m0_bus_read        = rst_n & active_s & rd_sel_s & ~tmo_hit_s;
    m0_bus_write       = rst_n & active_s & wr_sel_s & ~rd_sel_s & ~tmo_hit_s;
    s0_bus_waitrequest = 1'b1;
    s1_bus_waitrequest = 1'b1;
    s0_bus_readdata    = {BUS_DATA_W{1'b0}};
    s1_bus_readdata    = {BUS_DATA_W{1'b0}};
    s0_bus_response    = RESP_OKAY;
    s1_bus_response    = RESP_OKAY;
    if (!rst_n) begin
      s0_bus_waitrequest = 1'b1;
      s1_bus_waitrequest = 1'b1;
    end else if ((state_r == ARB_IDLE) && !any_req_s) begin
      s0_bus_waitrequest = 1'b0;
      s1_bus_waitrequest = 1'b0;
    end else if (!sel_s) begin
      s0_bus_waitrequest = ~done_s;
      s0_bus_readdata    = rdata_s;
      s0_bus_response    = resp_s;
    end else begin
      s1_bus_waitrequest = ~done_s;
      s1_bus_readdata    = rdata_s;
      s1_bus_response    = resp_s;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Directed scoreboard bench for bus_arbiter_2to1; timeout scenario runs only
// when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter_2to1;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  resp;
    bit          chk_rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_addr [2];
  logic [31:0] s_wdata [2];
  logic [3:0]  s_be [2];
  logic [1:0]  s_read = 2'b00;
  logic [1:0]  s_write = 2'b00;
  logic [31:0] s_rdata [2];
  logic [1:0]  s_resp [2];
  logic [1:0]  s_wait;
  logic [31:0] m0_bus_addr, m0_bus_writedata, m0_bus_readdata;
  logic        m0_bus_read, m0_bus_write, m0_bus_waitrequest, timeout_pulse;
  logic [3:0]  m0_bus_byteenable;
  logic [1:0]  m0_bus_response;

  // slave model controls
  int          stall_len = 0;
  bit          slv_forever = 1'b0;
  logic [31:0] slv_key = 32'h0;
  logic [1:0]  slv_resp = 2'b00;
  int          slv_cnt;
  int          rd_hi = 0;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  bus_arbiter_2to1 #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_bus_addr(s_addr[0]), .s0_bus_read(s_read[0]), .s0_bus_write(s_write[0]),
    .s0_bus_writedata(s_wdata[0]), .s0_bus_byteenable(s_be[0]),
    .s0_bus_readdata(s_rdata[0]), .s0_bus_response(s_resp[0]), .s0_bus_waitrequest(s_wait[0]),
    .s1_bus_addr(s_addr[1]), .s1_bus_read(s_read[1]), .s1_bus_write(s_write[1]),
    .s1_bus_writedata(s_wdata[1]), .s1_bus_byteenable(s_be[1]),
    .s1_bus_readdata(s_rdata[1]), .s1_bus_response(s_resp[1]), .s1_bus_waitrequest(s_wait[1]),
    .m0_bus_addr(m0_bus_addr), .m0_bus_read(m0_bus_read), .m0_bus_write(m0_bus_write),
    .m0_bus_writedata(m0_bus_writedata), .m0_bus_byteenable(m0_bus_byteenable),
    .m0_bus_readdata(m0_bus_readdata), .m0_bus_response(m0_bus_response),
    .m0_bus_waitrequest(m0_bus_waitrequest), .timeout_pulse(timeout_pulse)
  );

  // Slave: stalls stall_len cycles per transfer (or forever), data = addr ^ key.
  assign m0_bus_waitrequest = slv_forever | (slv_cnt < stall_len);
  assign m0_bus_readdata    = m0_bus_addr ^ slv_key;
  assign m0_bus_response    = slv_resp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) slv_cnt <= 0;
    else if (!(m0_bus_read | m0_bus_write)) slv_cnt <= 0;
    else if (m0_bus_waitrequest) slv_cnt <= slv_cnt + 1;
    else slv_cnt <= 0;
  end

  always @(negedge clk) if (m0_bus_read) rd_hi <= rd_hi + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completion seen by a master is matched against the queue.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst_n && (s_read[m] | s_write[m]) && !s_wait[m]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: master %0d addr %h, none queued", m, m0_bus_addr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cmpl_master", m, mon_e.m);
          chk("cmpl_addr", m0_bus_addr, mon_e.addr);
          chk("cmpl_resp", {30'd0, s_resp[m]}, {30'd0, mon_e.resp});
          if (mon_e.chk_rd) chk("cmpl_rdata", s_rdata[m], mon_e.rdata);
        end
      end
    end
  end

  function automatic exp_t mk(input int m, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] r, input bit c);
    exp_t e;
    e.m = m; e.addr = a; e.rdata = d; e.resp = r; e.chk_rd = c;
    return e;
  endfunction

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic idle_master(input int m);
    s_read[m] = 1'b0;
    s_write[m] = 1'b0;
  endtask

  task automatic do_xfer(input int m, input bit rd, input logic [31:0] a, input logic [31:0] wd);
    bit done = 1'b0;
    s_addr[m] = a; s_wdata[m] = wd; s_be[m] = 4'hF;
    s_read[m] = rd; s_write[m] = !rd;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      done = !s_wait[m];
      @(posedge clk); #1;
    end
    if (!done) chk("xfer_timeout", 32'd0, 32'd1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sync(); sync();
    rst_n = 1'b1;
    sync();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    for (int m = 0; m < 2; m++) begin
      s_addr[m] = 32'h0; s_wdata[m] = 32'h0; s_be[m] = 4'h0;
    end
    // T1: reset state, then a same-cycle read
    s_read = 2'b11;
    #3;
    chk("rst_m0_read", {31'd0, m0_bus_read}, 32'd0);
    chk("rst_m0_write", {31'd0, m0_bus_write}, 32'd0);
    chk("rst_waits", {30'd0, s_wait}, 32'd3);
    s_read = 2'b00;
    sync(); sync();
    rst_n = 1'b1;
    sync();
    @(negedge clk);
    chk("idle_waits", {30'd0, s_wait}, 32'd0);
    chk("idle_strobes", {30'd0, m0_bus_read, m0_bus_write}, 32'd0);
    chk("idle_tmo", {31'd0, timeout_pulse}, 32'd0);
    sync();
    stall_len = 0; slv_key = 32'h1234_577C;
    exp_q.push_back(mk(0, 32'h0000_0104, 32'h1234_5678, 2'b00, 1'b1));
    snap = rd_hi;
    do_xfer(0, 1'b1, 32'h0000_0104, 32'h0);
    idle_master(0);
    sync();
    chk("t1_read_cycles", rd_hi - snap, 32'd1);

    // T2: simultaneous writes after reset, 3-cycle stalls each
    apply_reset();
    stall_len = 3; slv_key = 32'h0;
    exp_q.push_back(mk(0, 32'h100, 32'h0, 2'b00, 1'b0));
    exp_q.push_back(mk(1, 32'h200, 32'h0, 2'b00, 1'b0));
    fork
      begin do_xfer(0, 1'b0, 32'h100, 32'hA); idle_master(0); end
      begin do_xfer(1, 1'b0, 32'h200, 32'hB); idle_master(1); end
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          chk("t2_addr", m0_bus_addr, (i < 4) ? 32'h100 : 32'h200);
          chk("t2_wdata", m0_bus_writedata, (i < 4) ? 32'hA : 32'hB);
          chk("t2_be", {28'd0, m0_bus_byteenable}, 32'hF);
          chk("t2_write", {31'd0, m0_bus_write}, 32'd1);
          if (i < 4) chk("t2_s1_wait", {31'd0, s_wait[1]}, 32'd1);
          else chk("t2_s1_wait", {31'd0, s_wait[1]}, (i == 7) ? 32'd0 : 32'd1);
        end
      end
    join

    // T3: continuous contention, single-cycle transfers alternate
    stall_len = 0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(0, 32'h1000 + 32'(k * 4), 32'h1000 + 32'(k * 4), 2'b00, 1'b1));
      exp_q.push_back(mk(1, 32'h2000 + 32'(k * 4), 32'h2000 + 32'(k * 4), 2'b00, 1'b1));
    end
    fork
      begin
        for (int k = 0; k < 3; k++) do_xfer(0, 1'b1, 32'h1000 + 32'(k * 4), 32'h0);
        idle_master(0);
      end
      begin
        for (int k = 0; k < 3; k++) do_xfer(1, 1'b1, 32'h2000 + 32'(k * 4), 32'h0);
        idle_master(1);
      end
    join
    sync();

    // T4: s1 read stalled 5 cycles, SLVERR passed through, s0 toggling
    stall_len = 5; slv_resp = 2'b10;
    exp_q.push_back(mk(1, 32'h300, 32'h300, 2'b10, 1'b1));
    fork
      begin do_xfer(1, 1'b1, 32'h300, 32'h0); idle_master(1); end
      begin
        s_addr[0] = 32'h0000_0BAD;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk("t4_addr", m0_bus_addr, 32'h300);
          chk("t4_read", {31'd0, m0_bus_read}, 32'd1);
          chk("t4_s0_wait", {31'd0, s_wait[0]}, 32'd1);
          chk("t4_s1_wait", {31'd0, s_wait[1]}, (i == 5) ? 32'd0 : 32'd1);
          @(posedge clk); #1;
          s_read[0] = (i < 3) ? ~s_read[0] : 1'b0;
        end
      end
    join
    slv_resp = 2'b00;
    sync();

    // T5: async reset during a stall, then master 0 wins a tie
    stall_len = 0;
    exp_q.push_back(mk(0, 32'h40, 32'h40, 2'b00, 1'b1));
    do_xfer(0, 1'b1, 32'h40, 32'h0);
    idle_master(0);
    slv_forever = 1'b1;
    s_addr[1] = 32'h450; s_wdata[1] = 32'h55; s_write[1] = 1'b1;
    @(negedge clk);
    chk("t5_busy_write", {31'd0, m0_bus_write}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t5_no_tmo", {31'd0, timeout_pulse}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_write", {31'd0, m0_bus_write}, 32'd0);
    chk("t5_async_waits", {30'd0, s_wait}, 32'd3);
    idle_master(1);
    slv_forever = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    sync();
    exp_q.push_back(mk(0, 32'h500, 32'h500, 2'b00, 1'b1));
    exp_q.push_back(mk(1, 32'h600, 32'h600, 2'b00, 1'b1));
    fork
      begin do_xfer(0, 1'b1, 32'h500, 32'h0); idle_master(0); end
      begin do_xfer(1, 1'b1, 32'h600, 32'h0); idle_master(1); end
    join
    sync();

`ifdef BUS_ARB_TIMEOUT_EN
    // T6: slave stalls forever, watchdog forces SLVERR on the 8th BUSY cycle
    slv_forever = 1'b1; slv_key = 32'h5555_5555;
    exp_q.push_back(mk(0, 32'h800, 32'h0, 2'b10, 1'b1));
    exp_q.push_back(mk(1, 32'h700, 32'h0, 2'b10, 1'b1));
    fork
      begin do_xfer(0, 1'b1, 32'h800, 32'h0); idle_master(0); end
      begin do_xfer(1, 1'b1, 32'h700, 32'h0); idle_master(1); end
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("t6_pulse", {31'd0, timeout_pulse}, (i == 8) ? 32'd1 : 32'd0);
          chk("t6_read", {31'd0, m0_bus_read}, (i == 8) ? 32'd0 : 32'd1);
          if (i == 9) chk("t6_next_addr", m0_bus_addr, 32'h700);
        end
      end
    join
    slv_forever = 1'b0;
    sync();
`endif

    sync(); sync();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
